bram_dual_port_arbiter: RTL and testbench

- Shares the two ports of a true dual-port block RAM among NUM_REQ requesters, granting up to two requests per cycle.
- Suppresses every same-address port pair that includes a write, so the RAM never returns an undefined value to a requester.
- Routes the 1-cycle-latency read data back to the requester that issued each read.
- Sits between client logic and the dual-port RAM instance, driving all RAM port-A/B inputs.

---
 rtl/bram_dual_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_bram_dual_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_dual_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bram_dual_port_arbiter
// Brief   : Round-robin arbiter granting up to two requesters per cycle onto
//           the A/B ports of a true dual-port BRAM, with read-data return.
// Revision: 1.0
// ============================================================================
module bram_dual_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ-1:0]            REQ_WE,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [NUM_REQ-1:0]            RESP_VALID,
  output logic [NUM_REQ*DATA_WIDTH-1:0] RESP_DATA,
  output logic [DATA_WIDTH-1:0]         DI_A,
  output logic [ADDR_WIDTH-1:0]         ADDR_A,
  output logic                          WE_A,
  output logic                          RE_A,
  input  logic [DATA_WIDTH-1:0]         DO_A,
  output logic [DATA_WIDTH-1:0]         DI_B,
  output logic [ADDR_WIDTH-1:0]         ADDR_B,
  output logic                          WE_B,
  output logic                          RE_B,
  input  logic [DATA_WIDTH-1:0]         DO_B,
  output logic [15:0]                   CONFLICT_COUNT
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr[gi] = REQ_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_data[gi] = REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic               a_rd_q, a_rd_d, b_rd_q, b_rd_d;
  logic [PTR_W-1:0]   a_tag_q, a_tag_d, b_tag_q, b_tag_d;
  logic [15:0]        conflict_cnt_q, conflict_cnt_d;

  logic [PTR_W:0]     w_scan_sum;
  logic [PTR_W-1:0]   w_scan_idx;
  logic [PTR_W-1:0]   w_g0_idx, w_g1_idx;
  logic               w_g0_vld, w_g1_vld;
  logic               w_conflict, w_gnt_a, w_gnt_b;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Circular scan from rr_ptr: first valid goes to port A, second to port B.
  always_comb begin
    w_g0_vld   = 1'b0;
    w_g1_vld   = 1'b0;
    w_g0_idx   = '0;
    w_g1_idx   = '0;
    w_scan_sum = '0;
    w_scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (w_scan_sum >= (PTR_W+1)'(NUM_REQ))
        w_scan_sum = w_scan_sum - (PTR_W+1)'(NUM_REQ);
      w_scan_idx = w_scan_sum[PTR_W-1:0];
      if (REQ_VALID[w_scan_idx]) begin
        if (!w_g0_vld) begin
          w_g0_vld = 1'b1;
          w_g0_idx = w_scan_idx;
        end else if (!w_g1_vld) begin
          w_g1_vld = 1'b1;
          w_g1_idx = w_scan_idx;
        end
      end
    end
  end

  assign w_conflict = w_g0_vld && w_g1_vld &&
                      (w_addr[w_g0_idx] == w_addr[w_g1_idx]) &&
                      (REQ_WE[w_g0_idx] || REQ_WE[w_g1_idx]);
  assign w_gnt_a    = w_g0_vld && !RST;
  assign w_gnt_b    = w_g1_vld && !w_conflict && !RST;

  always_comb begin
    REQ_READY      = '0;
    DI_A           = '0;
    ADDR_A         = '0;
    WE_A           = 1'b0;
    RE_A           = 1'b0;
    DI_B           = '0;
    ADDR_B         = '0;
    WE_B           = 1'b0;
    RE_B           = 1'b0;
    rr_ptr_d       = rr_ptr_q;
    a_rd_d         = w_gnt_a && !REQ_WE[w_g0_idx];
    b_rd_d         = w_gnt_b && !REQ_WE[w_g1_idx];
    a_tag_d        = w_g0_idx;
    b_tag_d        = w_g1_idx;
    resp_valid_d   = '0;
    conflict_cnt_d = conflict_cnt_q;

    if (w_gnt_a) begin
      REQ_READY[w_g0_idx] = 1'b1;
      DI_A     = w_data[w_g0_idx];
      ADDR_A   = w_addr[w_g0_idx];
      WE_A     = REQ_WE[w_g0_idx];
      RE_A     = !REQ_WE[w_g0_idx];
      rr_ptr_d = f_next(w_g0_idx);
    end
    if (w_gnt_b) begin
      REQ_READY[w_g1_idx] = 1'b1;
      DI_B     = w_data[w_g1_idx];
      ADDR_B   = w_addr[w_g1_idx];
      WE_B     = REQ_WE[w_g1_idx];
      RE_B     = !REQ_WE[w_g1_idx];
      rr_ptr_d = f_next(w_g1_idx);
    end
    if (a_rd_d) resp_valid_d[w_g0_idx] = 1'b1;
    if (b_rd_d) resp_valid_d[w_g1_idx] = 1'b1;
    if (w_conflict && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q       <= '0;
      resp_valid_q   <= '0;
      a_rd_q         <= 1'b0;
      b_rd_q         <= 1'b0;
      a_tag_q        <= '0;
      b_tag_q        <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      resp_valid_q   <= resp_valid_d;
      a_rd_q         <= a_rd_d;
      b_rd_q         <= b_rd_d;
      a_tag_q        <= a_tag_d;
      b_tag_q        <= b_tag_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Responses still pending when reset is raised are hidden immediately.
  assign RESP_VALID     = resp_valid_q & ~{NUM_REQ{RST}};
  assign CONFLICT_COUNT = conflict_cnt_q;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
      assign RESP_DATA[gi*DATA_WIDTH +: DATA_WIDTH] =
        (a_rd_q && (a_tag_q == PTR_W'(gi))) ? DO_A :
        (b_rd_q && (b_tag_q == PTR_W'(gi))) ? DO_B : '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bram_dual_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bram_dual_port_arbiter
// Brief   : Randomized bench for bram_dual_port_arbiter against a queue-based
//           arbitration/memory reference model, with a behavioural BRAM.
// Revision: 1.0
// ============================================================================
module tb_bram_dual_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MD = 1 << AW;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ_VALID, REQ_WE, REQ_READY, RESP_VALID;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*DW-1:0] REQ_DATA, RESP_DATA;
  logic [DW-1:0]   DI_A, DI_B, DO_A, DO_B;
  logic [AW-1:0]   ADDR_A, ADDR_B;
  logic            WE_A, RE_A, WE_B, RE_B;
  logic [15:0]     CONFLICT_COUNT;

  always #5 CLK = ~CLK;

  bram_dual_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA),
    .DI_A(DI_A), .ADDR_A(ADDR_A), .WE_A(WE_A), .RE_A(RE_A), .DO_A(DO_A),
    .DI_B(DI_B), .ADDR_B(ADDR_B), .WE_B(WE_B), .RE_B(RE_B), .DO_B(DO_B),
    .CONFLICT_COUNT(CONFLICT_COUNT)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 5) return 32'hAB;
    return 32'(a) * 32'h0001_0003 + 32'h00C0_0000;
  endfunction

  // Behavioural true dual-port BRAM, registered read output.
  logic          tb_init;
  logic [DW-1:0] ram [MD];
  always @(posedge CLK) begin
    if (tb_init) begin
      for (int i = 0; i < MD; i++) ram[i] <= init_val(i);
    end else begin
      if (WE_A) ram[ADDR_A] <= DI_A;
      if (WE_B) ram[ADDR_B] <= DI_B;
      if (RE_A) DO_A <= ram[ADDR_A];
      if (RE_B) DO_B <= ram[ADDR_B];
    end
  end

  int n_cmp, n_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester state, held until granted.
  bit   [N-1:0]  s_v, s_we;
  logic [AW-1:0] s_addr [N];
  logic [DW-1:0] s_data [N];

  // Reference model state.
  logic [DW-1:0] m_mem [MD];
  int            m_ptr, m_cnt;
  logic [N-1:0]  m_pend;
  logic [DW-1:0] m_pdata [N];
  logic [N-1:0]  last_gnt;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      REQ_VALID[i]          = s_v[i];
      REQ_WE[i]             = s_we[i];
      REQ_ADDR[i*AW +: AW]  = s_addr[i];
      REQ_DATA[i*DW +: DW]  = s_data[i];
    end
  endtask

  // One cycle: drive at the falling edge, check outputs, advance the model.
  task automatic step();
    int q[$];
    int g0, g1;
    bit have0, have1, conf;
    logic [N-1:0]  e_rdy;
    logic          e_wea, e_rea, e_web, e_reb;
    logic [AW-1:0] e_aa, e_ab;
    logic [DW-1:0] e_da, e_db;
    drive();
    #1;
    g0 = 0; g1 = 0; have0 = 0; have1 = 0; conf = 0;
    e_rdy = '0; e_wea = 0; e_rea = 0; e_web = 0; e_reb = 0;
    e_aa = '0; e_ab = '0; e_da = '0; e_db = '0;
    if (!RST) begin
      for (int k = 0; k < N; k++)
        if (s_v[(m_ptr + k) % N]) q.push_back((m_ptr + k) % N);
      if (q.size() > 0) begin have0 = 1; g0 = q[0]; end
      if (q.size() > 1) begin
        g1    = q[1];
        conf  = (s_addr[g0] == s_addr[g1]) && (s_we[g0] || s_we[g1]);
        have1 = !conf;
      end
    end
    if (have0) begin
      e_rdy[g0] = 1; e_aa = s_addr[g0]; e_da = s_data[g0];
      e_wea = s_we[g0]; e_rea = !s_we[g0];
    end
    if (have1) begin
      e_rdy[g1] = 1; e_ab = s_addr[g1]; e_db = s_data[g1];
      e_web = s_we[g1]; e_reb = !s_we[g1];
    end
    check_eq("req_ready", REQ_READY, e_rdy);
    check_eq("port_a", {WE_A, RE_A, ADDR_A, DI_A}, {e_wea, e_rea, e_aa, e_da});
    check_eq("port_b", {WE_B, RE_B, ADDR_B, DI_B}, {e_web, e_reb, e_ab, e_db});
    check_eq("resp_valid", RESP_VALID, RST ? '0 : m_pend);
    for (int i = 0; i < N; i++)
      if (!RST && m_pend[i])
        check_eq($sformatf("resp_data%0d", i), RESP_DATA[i*DW +: DW], m_pdata[i]);
    check_eq("conflict_cnt", CONFLICT_COUNT, m_cnt);

    if (RST) begin
      m_ptr = 0; m_cnt = 0; m_pend = '0;
    end else begin
      m_pend = '0;
      if (have0 && !s_we[g0]) begin m_pend[g0] = 1; m_pdata[g0] = m_mem[s_addr[g0]]; end
      if (have1 && !s_we[g1]) begin m_pend[g1] = 1; m_pdata[g1] = m_mem[s_addr[g1]]; end
      if (have0 && s_we[g0]) m_mem[s_addr[g0]] = s_data[g0];
      if (have1 && s_we[g1]) m_mem[s_addr[g1]] = s_data[g1];
      if (have1)      m_ptr = (g1 + 1) % N;
      else if (have0) m_ptr = (g0 + 1) % N;
      if (conf && m_cnt < 65535) m_cnt++;
    end
    last_gnt = e_rdy;
    @(negedge CLK);
  endtask

  // mode 0: granted requester goes idle; 1: random new request; 2: repeat same.
  task automatic refill(input int mode);
    for (int i = 0; i < N; i++) begin
      if (mode == 0 && last_gnt[i]) s_v[i] = 0;
      if (mode == 1 && (last_gnt[i] || !s_v[i]) && $urandom_range(0, 3) != 0) begin
        s_v[i]    = 1;
        s_we[i]   = 1'($urandom_range(0, 1));
        s_addr[i] = AW'($urandom_range(0, 7));
        s_data[i] = $urandom;
      end else if (mode == 1 && last_gnt[i]) begin
        s_v[i] = 0;
      end
    end
  endtask

  task automatic set_req(input int i, input bit we, input int a, input logic [DW-1:0] d);
    s_v[i] = 1; s_we[i] = we; s_addr[i] = AW'(a); s_data[i] = d;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    RST = 1; tb_init = 1;
    s_v = '0; s_we = '0;
    for (int i = 0; i < N; i++) begin s_addr[i] = '0; s_data[i] = '0; end
    for (int i = 0; i < MD; i++) m_mem[i] = init_val(i);
    m_ptr = 0; m_cnt = 0; m_pend = '0; last_gnt = '0;
    drive();
    repeat (2) @(negedge CLK);
    step();
    tb_init = 0; RST = 0;

    // single read by requester 2 of preloaded 0xAB
    set_req(2, 0, 5, '0); step(); refill(0); step();
    // dual read grant
    set_req(0, 0, 3, '0); set_req(1, 0, 7, '0); step(); refill(0); step();
    // write/read same-address conflict
    set_req(0, 1, 9, 32'h11); set_req(1, 0, 9, '0);
    step(); refill(0); step(); refill(0); step();
    // fairness with continuous distinct reads
    for (int i = 0; i < N; i++) set_req(i, 0, 10 + i, '0);
    repeat (8) begin step(); refill(2); end
    s_v = '0; step();
    // write-write to the same address, then read back
    set_req(2, 1, 4, 32'hCAFE0002); set_req(3, 1, 4, 32'hCAFE0003);
    step(); refill(0); step(); refill(0);
    set_req(0, 0, 4, '0); step(); refill(0); step();
    // reset the cycle after a read grant
    set_req(1, 0, 20, '0); step(); refill(0);
    RST = 1; step(); RST = 0; step();
    for (int i = 0; i < N; i++) set_req(i, 0, 30 + i, '0);
    step(); refill(0); step(); refill(0); step();

    // randomized traffic with occasional reset
    s_v = '0;
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 199) == 0);
      step();
      refill(1);
    end
    RST = 0;
    s_v = '0; step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
